fourbit_ser2par_ce_gen: RTL and testbench

Serial-to-parallel front end that assembles framed serial bits into a 4-bit word and presents it, with a one-cycle clock-enable strobe, to the downstream 4-bit posedge register with clock enable. Each frame carries WIDTH data bits plus an optional even-parity bit. Good frames produce `D` plus a `CE` pulse. Bad, aborted or stalled frames produce an `err` pulse and leave `D` unchanged.

---
 rtl/fourbit_ser2par_ce_gen_pkg.sv | 15 +
 rtl/fourbit_ser2par_ce_gen_gap_timer.sv | 30 +++
 rtl/fourbit_ser2par_ce_gen.sv | 145 ++++++++++++++
 tb/tb_fourbit_ser2par_ce_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fourbit_ser2par_ce_gen_pkg.sv
// Shared constants for the 4-bit serial-to-parallel front end and the
// benches of the downstream 4-bit clock-enable register.
package ff_pkg;

  // Frame receiver state encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/fourbit_ser2par_ce_gen_gap_timer.sv
// Idle-gap watchdog for an in-progress frame. Counts consecutive idle
// cycles while run is high; expired fires combinationally on the cycle
// whose edge makes the count reach TIMEOUT, so the owner can register
// its error strobe on that same edge.
module gap_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic R,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = run && !clr && (cnt == CW'(TIMEOUT - 1));

  // Idle-cycle counter; restarts after any valid bit or once it has fired.
  always_ff @(posedge clk) begin
    if (R || clr || expired) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fourbit_ser2par_ce_gen.sv
// Serial-to-parallel front end: assembles framed serial bits (optionally
// followed by an even-parity bit) into a word and presents it with a
// single-cycle clock-enable strobe. Bad, aborted or stalled frames give
// an err strobe and leave D untouched.
//
//   state  | meaning
//   IDLE   | waiting for a valid bit flagged with sof
//   DATA   | collecting data bits 1..WIDTH-1
//   PARITY | waiting for the even-parity bit
module fourbit_ser2par_ce_gen
  import ff_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 1,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             R,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] D,
  output logic             CE,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  // Where a freshly started frame goes after its first bit. A 1-bit frame
  // without parity completes immediately and never leaves IDLE.
  localparam state_t START_STATE = (WIDTH == 1) ? ((PARITY_EN != 0) ? PARITY : IDLE) : DATA;
  localparam bit     START_DONE  = (WIDTH == 1) && (PARITY_EN == 0);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             par;

  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] next_word;
  logic             last_data;
  logic             gap_run;
  logic             gap_clr;
  logic             expired;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    logic [WIDTH-1:0] res;
    if (MSB_FIRST != 0) begin
      res    = cur << 1;
      res[0] = b;
    end else begin
      res          = cur >> 1;
      res[WIDTH-1] = b;
    end
    return res;
  endfunction

  assign first_word = shift_in('0, din);
  assign next_word  = shift_in(sr, din);
  assign last_data  = (cnt == CW'(WIDTH - 1));
  assign busy       = (state != IDLE);
  assign gap_run    = busy && !din_valid;
  assign gap_clr    = !busy || din_valid;

  gap_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_gap_timer (
    .clk    (clk),
    .R      (R),
    .clr    (gap_clr),
    .run    (gap_run),
    .expired(expired)
  );

  // Frame FSM with shift register, bit counter, parity accumulator and
  // registered D/CE/err outputs.
  always_ff @(posedge clk) begin
    if (R) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      par   <= 1'b0;
      D     <= '0;
      CE    <= 1'b0;
      err   <= 1'b0;
    end else begin
      CE  <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (din_valid && sof) begin
            sr  <= first_word;
            par <= din;
            cnt <= CW'(1);
            if (START_DONE) begin
              D  <= first_word;
              CE <= 1'b1;
            end
            state <= START_STATE;
          end
        end
        DATA, PARITY: begin
          if (expired) begin
            err   <= 1'b1;
            sr    <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else if (din_valid && sof) begin
            // Abort the current frame; this bit opens the next one.
            err   <= 1'b1;
            sr    <= first_word;
            par   <= din;
            cnt   <= CW'(1);
            state <= START_STATE;
          end else if (din_valid && state == DATA) begin
            sr  <= next_word;
            par <= par ^ din;
            cnt <= cnt + CW'(1);
            if (last_data) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
              end else begin
                D     <= next_word;
                CE    <= 1'b1;
                state <= IDLE;
              end
            end
          end else if (din_valid) begin
            if (par ^ din) begin
              err <= 1'b1;
            end else begin
              D  <= sr;
              CE <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fourbit_ser2par_ce_gen.sv
// Bench for the serial-to-parallel front end. Two instances share the
// same stimulus: one assembling MSB first, one LSB first. A frame-level
// reference model tracks the received bits as a queue and decides the
// outcome of each frame from its bit count, parity and idle gaps.
module tb_fourbit_ser2par_ce_gen;

  logic       clk;
  logic       R;
  logic       din;
  logic       din_valid;
  logic       sof;
  logic [3:0] d_msb;
  logic [3:0] d_lsb;
  logic       ce_msb, ce_lsb;
  logic       err_msb, err_lsb;
  logic       busy_msb, busy_lsb;

  int checks = 0;
  int errors = 0;

  fourbit_ser2par_ce_gen #(
    .WIDTH(4), .MSB_FIRST(1), .PARITY_EN(1), .TIMEOUT(15)
  ) dut (
    .clk(clk), .R(R), .din(din), .din_valid(din_valid), .sof(sof),
    .D(d_msb), .CE(ce_msb), .err(err_msb), .busy(busy_msb)
  );

  fourbit_ser2par_ce_gen #(
    .WIDTH(4), .MSB_FIRST(0), .PARITY_EN(1), .TIMEOUT(15)
  ) dut_lsb (
    .clk(clk), .R(R), .din(din), .din_valid(din_valid), .sof(sof),
    .D(d_lsb), .CE(ce_lsb), .err(err_lsb), .busy(busy_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         q[$];
  int         gap;
  bit         in_frame;
  bit         model_on = 0;
  logic [3:0] m_dm, m_dl;
  logic       m_ce, m_err;

  task automatic model_step();
    bit p;
    if (R) begin
      in_frame = 0;
      q.delete();
      gap   = 0;
      m_dm  = 4'h0;
      m_dl  = 4'h0;
      m_ce  = 1'b0;
      m_err = 1'b0;
      model_on = 1;
      return;
    end
    m_ce  = 1'b0;
    m_err = 1'b0;
    if (!in_frame) begin
      if (din_valid && sof) begin
        q = {din};
        in_frame = 1;
        gap = 0;
      end
    end else if (din_valid) begin
      gap = 0;
      if (sof) begin
        m_err = 1'b1;
        q = {din};
      end else begin
        q.push_back(din);
        if (q.size() == 5) begin
          p = 0;
          foreach (q[i]) p ^= q[i];
          if (!p) begin
            m_ce = 1'b1;
            for (int i = 0; i < 4; i++) begin
              m_dm[3-i] = q[i];
              m_dl[i]   = q[i];
            end
          end else begin
            m_err = 1'b1;
          end
          in_frame = 0;
        end
      end
    end else begin
      gap++;
      if (gap == 15) begin
        m_err = 1'b1;
        in_frame = 0;
      end
    end
  endtask

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    model_step();
    #1;
    if (model_on) begin
      chk("D_msb", d_msb, m_dm);
      chk("D_lsb", d_lsb, m_dl);
      chk("CE_msb", {3'b0, ce_msb}, {3'b0, m_ce});
      chk("CE_lsb", {3'b0, ce_lsb}, {3'b0, m_ce});
      chk("err_msb", {3'b0, err_msb}, {3'b0, m_err});
      chk("err_lsb", {3'b0, err_lsb}, {3'b0, m_err});
      chk("busy_msb", {3'b0, busy_msb}, {3'b0, in_frame});
      chk("busy_lsb", {3'b0, busy_lsb}, {3'b0, in_frame});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r, input logic v, input logic s, input logic b);
    @(negedge clk);
    R = r; din_valid = v; sof = s; din = b;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [3:0] w, input logic p);
    for (int i = 3; i >= 0; i--) drive(0, 1, (i == 3), w[i]);
    drive(0, 1, 0, p);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] dm, input logic [3:0] dl,
                            input logic ce, input logic er, input logic bz);
    chk({tag, "_D_msb"}, d_msb, dm);
    chk({tag, "_D_lsb"}, d_lsb, dl);
    chk({tag, "_CE"}, {3'b0, ce_msb}, {3'b0, ce});
    chk({tag, "_err"}, {3'b0, err_msb}, {3'b0, er});
    chk({tag, "_busy"}, {3'b0, busy_msb}, {3'b0, bz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    R = 1'b1; din = 1'b0; din_valid = 1'b0; sof = 1'b0;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    after_edge();
    expect_out("reset", 4'h0, 4'h0, 0, 0, 0);

    // Good frame 1,0,1,1 with parity 1.
    send_word(4'b1011, 1'b1);
    after_edge();
    expect_out("good", 4'b1011, 4'b1101, 1, 0, 0);
    drive(0, 0, 0, 0);
    after_edge();
    expect_out("good_ce_drop", 4'b1011, 4'b1101, 0, 0, 0);

    // Bad parity: 0,1,1,0 with parity 1.
    send_word(4'b0110, 1'b1);
    after_edge();
    expect_out("badpar", 4'b1011, 4'b1101, 0, 1, 0);

    // 14-cycle gap inside a frame is tolerated.
    drive(0, 1, 1, 1); drive(0, 1, 0, 1); drive(0, 1, 0, 0);
    for (int i = 0; i < 14; i++) drive(0, 0, 0, 0);
    drive(0, 1, 0, 1); drive(0, 1, 0, 1);
    after_edge();
    expect_out("gap14", 4'b1101, 4'b1011, 1, 0, 0);

    // 15-cycle gap times out; late bits ignored.
    drive(0, 1, 1, 1); drive(0, 1, 0, 1); drive(0, 1, 0, 0);
    for (int i = 0; i < 15; i++) drive(0, 0, 0, 0);
    after_edge();
    expect_out("timeout", 4'b1101, 4'b1011, 0, 1, 0);
    drive(0, 1, 0, 1); drive(0, 1, 0, 1);
    after_edge();
    expect_out("late_bits", 4'b1101, 4'b1011, 0, 0, 0);

    // Abort: sof on bit 3, new frame 1,0,1,0 parity 0.
    drive(0, 1, 1, 1); drive(0, 1, 0, 0); drive(0, 1, 1, 1);
    after_edge();
    expect_out("abort", 4'b1101, 4'b1011, 0, 1, 1);
    drive(0, 1, 0, 0); drive(0, 1, 0, 1); drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    after_edge();
    expect_out("abort_new", 4'b1010, 4'b0101, 1, 0, 0);

    // Back-to-back frames A then 5.
    send_word(4'hA, 1'b0);
    after_edge();
    expect_out("b2b_A", 4'hA, 4'h5, 1, 0, 0);
    send_word(4'h5, 1'b0);
    after_edge();
    expect_out("b2b_5", 4'h5, 4'hA, 1, 0, 0);

    // Reset mid-frame, then a full frame 1,0,0,0 parity 1.
    drive(0, 1, 1, 1); drive(0, 1, 0, 0); drive(1, 0, 0, 0);
    after_edge();
    expect_out("midreset", 4'h0, 4'h0, 0, 0, 0);
    send_word(4'b1000, 1'b1);
    after_edge();
    expect_out("post_reset", 4'b1000, 4'b0001, 1, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        int len = $urandom_range(10, 18);
        for (int k = 0; k < len; k++) drive(0, 0, 0, 0);
      end else begin
        drive(($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)));
      end
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    after_edge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
